// File: rtl/morra_pkg.sv
// morra_pkg: move/result codes, FSM states and move helpers shared by the player driver and the referee bench.
package morra_pkg;
    localparam logic [1:0] MOSSA_NULLA = 2'b00;
    localparam logic [1:0] MOSSA_1     = 2'b01;
    localparam logic [1:0] MOSSA_2     = 2'b10;
    localparam logic [1:0] MOSSA_3     = 2'b11;
    localparam logic [1:0] RIS_NESSUNO = 2'b00;
    localparam logic [1:0] RIS_PRIMO   = 2'b01;
    localparam logic [1:0] RIS_SECONDO = 2'b10;
    localparam logic [1:0] RIS_PARI    = 2'b11;
    localparam logic [3:0] VINCE_A     = 4'b0111;
    localparam logic [3:0] VINCE_B     = 4'b1001;
    localparam logic [3:0] VINCE_C     = 4'b1110;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] AVVIO = 2'd1;
    localparam logic [1:0] GIOCO = 2'd2;
    localparam logic [1:0] FINE  = 2'd3;

    function automatic logic [1:0] esito(input logic [1:0] primo, input logic [1:0] secondo);
        return (primo == secondo) ? RIS_PARI :
               ({primo, secondo} inside {VINCE_A, VINCE_B, VINCE_C}) ? RIS_PRIMO : RIS_SECONDO;
    endfunction

    // A raw 00 becomes 01; the previous winner may not repeat its winning move.
    function automatic logic [1:0] legalizza(input logic [1:0] grezza, input logic vincitore,
                                             input logic [1:0] mossa_vietata);
        logic [1:0] v;
        v = (grezza == MOSSA_NULLA) ? MOSSA_1 : grezza;
        return (vincitore && v == mossa_vietata) ? ((v == MOSSA_3) ? MOSSA_1 : v + 2'd1) : v;
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4, shift left) exposing its two low bits as a raw move.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output logic [1:0] grezza_o
);
    logic [7:0] stato_q;

    always_ff @(posedge clk) begin
        if (reset) stato_q <= SEED;
        else if (en_i) stato_q <= {stato_q[6:0], stato_q[7] ^ stato_q[5] ^ stato_q[4] ^ stato_q[3]};
    end

    assign grezza_o = stato_q[1:0];
endmodule

// File: rtl/giocatori_driver.sv
// giocatori_driver: generates both players' moves for the referee and cross-checks every manche outcome.
module giocatori_driver
    import morra_pkg::*;
#(
    parameter logic [7:0] SEED_PRIMO   = 8'hA5,
    parameter logic [7:0] SEED_SECONDO = 8'h3C,
    parameter logic [4:0] MAX_MANCHE   = 5'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       AVVIA,
    input  logic [3:0] CFG_TURNI,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic [1:0] RISULTATO,
    output logic       FATTO,
    output logic       ERRORE,
    output logic [4:0] CONTA_MANCHE
);
    logic [1:0] stato_q, stato_d;
    logic [2:0] vietata_q, vietata_d;
    logic [1:0] atteso_q, atteso_d;
    logic       atteso_valido_q, atteso_valido_d;
    logic [1:0] ris_q, ris_d;
    logic       err_q, err_d;
    logic [4:0] conta_q, conta_d;
    logic [1:0] grezza_p, grezza_s, mossa_p, mossa_s, esito_c;
    logic       in_gioco, errato, finita, scaduto, esce;

    assign in_gioco = stato_q == GIOCO;

    lfsr8 #(.SEED(SEED_PRIMO))   u_lfsr_p (.clk(clk), .reset(reset), .en_i(in_gioco), .grezza_o(grezza_p));
    lfsr8 #(.SEED(SEED_SECONDO)) u_lfsr_s (.clk(clk), .reset(reset), .en_i(in_gioco), .grezza_o(grezza_s));

    assign mossa_p = legalizza(grezza_p, !vietata_q[2], vietata_q[1:0]);
    assign mossa_s = legalizza(grezza_s, vietata_q[2], vietata_q[1:0]);
    assign esito_c = esito(mossa_p, mossa_s);

    // The referee answers one cycle late, so checks only start once a pair has been issued.
    assign errato  = in_gioco && atteso_valido_q && MANCHE != atteso_q;
    assign finita  = in_gioco && atteso_valido_q && PARTITA != RIS_NESSUNO;
    assign scaduto = in_gioco && atteso_valido_q && PARTITA == RIS_NESSUNO && conta_q == MAX_MANCHE;
    assign esce    = errato || finita || scaduto;

    always_comb begin
        stato_d = (stato_q == IDLE || stato_q == FINE) ? (AVVIA ? AVVIO : stato_q) :
                  (stato_q == AVVIO) ? GIOCO : (esce ? FINE : GIOCO);
        vietata_d = (stato_q == AVVIO) ? 3'b000 :
                    !in_gioco ? vietata_q :
                    (esito_c == RIS_PRIMO) ? {1'b0, mossa_p} :
                    (esito_c == RIS_SECONDO) ? {1'b1, mossa_s} : 3'b000;
        atteso_d = in_gioco ? esito_c : atteso_q;
        atteso_valido_d = (stato_q == AVVIO) ? 1'b0 : (in_gioco ? 1'b1 : atteso_valido_q);
        conta_d = (stato_q == AVVIO) ? 5'd0 :
                  (in_gioco && !esce && conta_q != 5'd31) ? conta_q + 5'd1 : conta_q;
        ris_d = (in_gioco && esce) ? PARTITA : ris_q;
        err_d = (stato_d == AVVIO) ? 1'b0 : ((errato || scaduto) ? 1'b1 : err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stato_q         <= IDLE;
            vietata_q       <= 3'b000;
            atteso_q        <= RIS_NESSUNO;
            atteso_valido_q <= 1'b0;
            ris_q           <= RIS_NESSUNO;
            err_q           <= 1'b0;
            conta_q         <= 5'd0;
        end else begin
            stato_q         <= stato_d;
            vietata_q       <= vietata_d;
            atteso_q        <= atteso_d;
            atteso_valido_q <= atteso_valido_d;
            ris_q           <= ris_d;
            err_q           <= err_d;
            conta_q         <= conta_d;
        end
    end

    assign PRIMO        = in_gioco ? mossa_p : ((stato_q == AVVIO) ? CFG_TURNI[3:2] : MOSSA_NULLA);
    assign SECONDO      = in_gioco ? mossa_s : ((stato_q == AVVIO) ? CFG_TURNI[1:0] : MOSSA_NULLA);
    assign INIZIA       = stato_q == AVVIO;
    assign FATTO        = stato_q == FINE;
    assign RISULTATO    = ris_q;
    assign ERRORE       = err_q;
    assign CONTA_MANCHE = conta_q;
endmodule

// File: tb/tb_giocatori_driver.sv
// tb_giocatori_driver: scoreboard bench with a behavioural referee and a reference move predictor.
module tb_giocatori_driver;
    logic       clk = 1'b0, reset = 1'b1, AVVIA = 1'b0;
    logic [3:0] CFG_TURNI = 4'd0;
    logic [1:0] MANCHE = 2'd0, PARTITA = 2'd0;
    logic [1:0] PRIMO, SECONDO, RISULTATO;
    logic       INIZIA, FATTO, ERRORE;
    logic [4:0] CONTA_MANCHE;

    giocatori_driver dut (
        .clk(clk), .reset(reset), .AVVIA(AVVIA), .CFG_TURNI(CFG_TURNI),
        .MANCHE(MANCHE), .PARTITA(PARTITA), .PRIMO(PRIMO), .SECONDO(SECONDO),
        .INIZIA(INIZIA), .RISULTATO(RISULTATO), .FATTO(FATTO), .ERRORE(ERRORE),
        .CONTA_MANCHE(CONTA_MANCHE)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic int legal(input int raw, input bit banned, input int ban);
        int m;
        m = (raw == 0) ? 1 : raw;
        if (banned && m == ban) m = m % 3 + 1;
        return m;
    endfunction

    // Morra on {1,2,3}: 1 beats 3, 2 beats 1, 3 beats 2.
    function automatic int res_of(input int p, input int s);
        if (p == s) return 3;
        return ((s - p + 3) % 3 == 2) ? 1 : 2;
    endfunction

    logic [7:0] mp = 8'hA5, ms = 8'h3C;
    int exp_q[$], res_a[$], rec[$], rec1[$];
    logic [7:0] mpa[$], msa[$];
    int pops = 0;
    bit rec_on = 0;
    int ref_mode = 0, ref_n = 4;

    task automatic predict();
        logic [7:0] a, b;
        int vw, vm, p, s, r;
        exp_q.delete(); res_a.delete(); mpa.delete(); msa.delete();
        a = mp; b = ms; vw = 0; vm = 0;
        for (int i = 0; i < 25; i++) begin
            p = legal(int'(a[1:0]), vw == 1, vm);
            s = legal(int'(b[1:0]), vw == 2, vm);
            r = res_of(p, s);
            exp_q.push_back(p * 4 + s);
            res_a.push_back(r);
            vw = (r == 3) ? 0 : r;
            vm = (r == 1) ? p : ((r == 2) ? s : 0);
            a = step(a); b = step(b);
            mpa.push_back(a); msa.push_back(b);
        end
    endtask

    // Monitor: every GIOCO cycle presents one pair, checked against the predicted queue.
    always @(negedge clk) begin
        if (!reset && !FATTO && !INIZIA && PRIMO != 2'b00) begin
            if (exp_q.size() == 0) chk("pair_unexpected", {PRIMO, SECONDO}, 0);
            else chk("pair", {28'd0, PRIMO, SECONDO}, exp_q.pop_front());
            pops++;
            if (rec_on && rec.size() < 4) rec.push_back(int'({PRIMO, SECONDO}));
        end
    end

    // Referee: answers each pair one cycle later; mode 0 ends after ref_n manche,
    // mode 1 lies on the first PRIMO win, mode 2 never ends the match.
    int pend_r = 0, played = 0, w1 = 0, w2 = 0;
    bit pend_v = 0, flipped = 0;
    always @(negedge clk) begin
        if (reset) begin
            pend_v = 0; played = 0; w1 = 0; w2 = 0; flipped = 0;
            MANCHE = 2'd0; PARTITA = 2'd0;
        end else begin
            MANCHE = pend_v ? 2'(pend_r) : 2'd0;
            PARTITA = 2'd0;
            if (pend_v) begin
                played++;
                if (pend_r == 1) w1++;
                if (pend_r == 2) w2++;
                if (ref_mode == 1 && !flipped && pend_r == 1) begin
                    MANCHE = 2'd2;
                    flipped = 1;
                end
                if (ref_mode == 0 && played == ref_n) PARTITA = (w1 > w2) ? 2'd1 : ((w2 > w1) ? 2'd2 : 2'd3);
            end
            if (!FATTO && !INIZIA && PRIMO != 2'b00) begin
                pend_r = res_of(int'(PRIMO), int'(SECONDO));
                pend_v = 1;
            end else begin
                pend_v = 0; played = 0; w1 = 0; w2 = 0; flipped = 0;
            end
        end
    end

    task automatic run_game(input logic [3:0] cfg, input int mode);
        int e_conta, e_err, e_ris, e_pops, n, a, b, j;
        predict();
        pops = 0;
        ref_mode = mode;
        ref_n = int'(cfg) + 4;
        e_err = 1; e_ris = 0; e_conta = 20; e_pops = 21;
        if (mode == 0) begin
            n = int'(cfg) + 4; a = 0; b = 0;
            for (int i = 0; i < n; i++) begin
                if (res_a[i] == 1) a++;
                if (res_a[i] == 2) b++;
            end
            e_ris = (a > b) ? 1 : ((b > a) ? 2 : 3);
            e_conta = n; e_pops = n + 1; e_err = 0;
        end else if (mode == 1) begin
            j = -1;
            for (int i = 0; i < 20; i++) if (j < 0 && res_a[i] == 1) j = i;
            if (j >= 0) begin
                e_conta = j + 1; e_pops = j + 2;
            end
        end
        @(negedge clk);
        CFG_TURNI = cfg;
        AVVIA = 1'b1;
        @(negedge clk);
        AVVIA = 1'b0;
        chk("inizia_on", INIZIA, 1);
        chk("avvio_moves", {PRIMO, SECONDO}, cfg);
        chk("avvio_errore", ERRORE, 0);
        @(negedge clk);
        chk("inizia_off", INIZIA, 0);
        for (int i = 0; i < 100 && !FATTO; i++) @(negedge clk);
        chk("fatto", FATTO, 1);
        chk("risultato", RISULTATO, e_ris);
        chk("errore", ERRORE, e_err);
        chk("conta_manche", CONTA_MANCHE, e_conta);
        chk("pairs_issued", pops, e_pops);
        @(negedge clk);
        chk("fine_hold", {FATTO, PRIMO, SECONDO, INIZIA}, 6'b100000);
        if (pops > 0) begin
            mp = mpa[pops - 1];
            ms = msa[pops - 1];
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk(nm, {PRIMO, SECONDO, INIZIA, RISULTATO, FATTO, ERRORE, CONTA_MANCHE}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("reset_state");
        reset = 1'b0;
        rec_on = 1;
        run_game(4'd0, 0);
        rec1 = rec;
        rec_on = 0;
        run_game(4'd3, 0);
        run_game(4'd5, 1);
        run_game(4'd2, 2);
        repeat (3) run_game(4'($urandom_range(0, 15)), 0);
        run_game(4'($urandom_range(0, 15)), int'($urandom_range(1, 2)));
        // Abort a game with reset, then replay from the seeds.
        predict();
        pops = 0; ref_mode = 0; ref_n = 4;
        @(negedge clk);
        CFG_TURNI = 4'd0;
        AVVIA = 1'b1;
        @(negedge clk);
        AVVIA = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("mid_reset_state");
        mp = 8'hA5; ms = 8'h3C;
        rec.delete();
        rec_on = 1;
        run_game(4'd0, 0);
        rec_on = 0;
        for (int i = 0; i < 4; i++)
            chk("replay_seq", (i < rec.size()) ? rec[i] : -1, (i < rec1.size()) ? rec1[i] : -2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
